prog_instr_mem: RTL and testbench

//  Parametrised, run-time loadable instruction ROM/RAM for the fetch stage.

---
 rtl/instr_mem_pkg.sv | 14 +
 rtl/imem_ram_1r1w.sv | 28 ++
 rtl/prog_instr_mem.sv | 136 +++++++++++++
 tb/tb_prog_instr_mem.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and defaults for the fetch-stage instruction memory.
// Imported by the RAM and the memory controller.
package instr_mem_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_LOAD
   } imem_state_e;

   localparam int unsigned DEF_DATA_W = 32;
   localparam logic [DEF_DATA_W-1:0] DEF_NOP = '0;

endpackage

// File: rtl/imem_ram_1r1w.sv
// Single write port, single registered read port storage array.
// rdata only changes on an enabled read, so it holds between fetches.
module imem_ram_1r1w #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int AW     = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/prog_instr_mem.sv
// Run-time loadable instruction memory: clears after reset, accepts a
// streamed image, then serves registered single-cycle fetches by PC.
module prog_instr_mem
   import instr_mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 32,
   parameter logic [DATA_W-1:0] NOP_WORD = DEF_NOP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] pc,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instruction,
   output logic              addr_fault,
   output logic              busy,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_done,
   output logic [ADDR_W:0]   ld_count
);

   localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [RAM_AW-1:0] CLR_LAST = RAM_AW'(DEPTH - 1);
   localparam logic [RAM_AW-1:0] CLR_ONE  = RAM_AW'(1);
   localparam logic [ADDR_W:0]   LD_LAST  = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0]   LD_ONE   = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);

   imem_state_e       state_q;
   imem_state_e       state_d;
   logic [RAM_AW-1:0] clr_ptr;
   logic [ADDR_W:0]   ld_count_q;
   logic              fetch_ok;
   logic              pc_oob;
   logic              load_end;
   logic              we;
   logic              re;
   logic [RAM_AW-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              nop_sel;

   assign pc_oob   = {1'b0, pc} >= DEPTH_W;
   assign fetch_ok = (state_q == ST_IDLE) && fetch_req;
   assign re       = fetch_ok && !pc_oob;
   assign busy     = (state_q != ST_IDLE);
   assign ld_count = ld_count_q;

   // nop_sel remembers whether the last accepted fetch was out of range
   assign instruction = nop_sel ? NOP_WORD : rdata;

   always_comb begin
      state_d  = state_q;
      we       = 1'b0;
      waddr    = clr_ptr;
      wdata    = NOP_WORD;
      load_end = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            we = 1'b1;
            if (clr_ptr == CLR_LAST) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (ld_start) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (ld_valid) begin
               we    = 1'b1;
               waddr = ld_count_q[RAM_AW-1:0];
               wdata = ld_data;
               if (ld_last || ld_count_q == LD_LAST) begin
                  load_end = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_CLEAR;
         clr_ptr     <= '0;
         ld_count_q  <= '0;
         ld_done     <= 1'b0;
         instr_valid <= 1'b0;
         addr_fault  <= 1'b0;
         nop_sel     <= 1'b1;
      end else begin
         state_q     <= state_d;
         ld_done     <= load_end;
         instr_valid <= fetch_ok;
         addr_fault  <= fetch_ok && pc_oob;
         if (fetch_ok) begin
            nop_sel <= pc_oob;
         end
         if (state_q == ST_CLEAR) begin
            clr_ptr <= clr_ptr + CLR_ONE;
         end else begin
            clr_ptr <= '0;
         end
         if (state_q == ST_IDLE && ld_start) begin
            ld_count_q <= '0;
         end else if (state_q == ST_LOAD && ld_valid) begin
            ld_count_q <= ld_count_q + LD_ONE;
         end
      end
   end

   imem_ram_1r1w #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (RAM_AW)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .re    (re),
      .raddr (pc[RAM_AW-1:0]),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_prog_instr_mem.sv
// Directed plus randomized bench for prog_instr_mem against an
// array-based model of the memory image and load rules.
module tb_prog_instr_mem;

   localparam int DEPTH = 32;
   localparam logic [31:0] NOP = 32'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req;
   logic [5:0]  pc;
   logic        instr_valid;
   logic [31:0] instruction;
   logic        addr_fault;
   logic        busy;
   logic        ld_start;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        ld_last;
   logic        ld_done;
   logic [6:0]  ld_count;

   logic [31:0] mem_m [DEPTH];
   logic [31:0] img [$];
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   prog_instr_mem #(
      .DATA_W   (32),
      .ADDR_W   (6),
      .DEPTH    (DEPTH),
      .NOP_WORD (NOP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_req   (fetch_req),
      .pc          (pc),
      .instr_valid (instr_valid),
      .instruction (instruction),
      .addr_fault  (addr_fault),
      .busy        (busy),
      .ld_start    (ld_start),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .ld_done     (ld_done),
      .ld_count    (ld_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reset, then time the clear phase; optionally hold a fetch of pc 0.
   task automatic do_reset(input bit hold_fetch);
      int cnt;
      rst = 1'b1;
      ld_start = 1'b0;
      ld_last = 1'b0;
      fetch_req = hold_fetch;
      pc = 6'd0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instruction, NOP);
      chk("rst_fault", addr_fault, 1'b0);
      chk("rst_ld_done", ld_done, 1'b0);
      chk("rst_ld_count", ld_count, 7'd0);
      chk("rst_busy", busy, 1'b1);
      rst = 1'b0;
      ld_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      chk("clear_cycles", cnt, 32);
      if (hold_fetch) begin
         @(negedge clk);
         fetch_req = 1'b0;
         chk("first_valid", instr_valid, 1'b1);
         chk("first_instr", instruction, NOP);
         chk("first_fault", addr_fault, 1'b0);
         @(negedge clk);
      end
   endtask

   task automatic load_img(input bit with_last);
      int n;
      int term;
      n = img.size();
      term = (with_last && n - 1 < DEPTH - 1) ? n - 1 : DEPTH - 1;
      ld_start = 1'b1;
      fetch_req = 1'b0;
      @(negedge clk);
      ld_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1;
         ld_data = img[i];
         ld_last = with_last && (i == n - 1);
         if (i <= term) mem_m[5'(i)] = img[i];
         @(negedge clk);
         chk("ld_done", ld_done, i == term);
      end
      ld_valid = 1'b0;
      ld_last = 1'b0;
      chk("ld_count", ld_count, 7'(term + 1));
      chk("busy_after_load", busy, 1'b0);
   endtask

   task automatic fetch(input int p);
      logic [31:0] e;
      e = (p >= DEPTH) ? NOP : mem_m[5'(p)];
      fetch_req = 1'b1;
      pc = 6'(p);
      @(negedge clk);
      fetch_req = 1'b0;
      chk("fetch_valid", instr_valid, 1'b1);
      chk("fetch_instr", instruction, e);
      chk("fetch_fault", addr_fault, p >= DEPTH);
      chk("ld_done_quiet", ld_done, 1'b0);
      @(negedge clk);
      chk("idle_valid", instr_valid, 1'b0);
      chk("idle_hold", instruction, e);
      chk("idle_fault", addr_fault, 1'b0);
   endtask

   initial begin
      ld_valid = 1'b0;
      ld_data = '0;
      do_reset(1'b1);

      img = {32'h10430020, 32'h00000031, 32'hDEADBEEF};
      load_img(1'b1);
      fetch(1);
      fetch(40);
      fetch(2);

      img = {};
      for (int i = 0; i < 40; i++) img.push_back($urandom);
      load_img(1'b0);
      fetch(31);
      fetch(0);

      // ld_start and a fetch in the same idle cycle
      ld_start = 1'b1;
      fetch_req = 1'b1;
      pc = 6'd1;
      @(negedge clk);
      ld_start = 1'b0;
      chk("cc_valid", instr_valid, 1'b1);
      chk("cc_instr", instruction, mem_m[1]);
      chk("cc_busy", busy, 1'b1);
      @(negedge clk);
      chk("load_fetch_valid", instr_valid, 1'b0);
      chk("load_instr_hold", instruction, mem_m[1]);
      fetch_req = 1'b0;
      ld_valid = 1'b1;
      ld_data = $urandom;
      ld_last = 1'b1;
      mem_m[0] = ld_data;
      @(negedge clk);
      ld_valid = 1'b0;
      ld_last = 1'b0;
      chk("cc_ld_done", ld_done, 1'b1);
      chk("cc_ld_count", ld_count, 7'd1);
      fetch(0);
      fetch(1);

      // reset in the middle of a load
      ld_start = 1'b1;
      @(negedge clk);
      ld_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1'b1;
         ld_data = $urandom;
         @(negedge clk);
      end
      do_reset(1'b0);
      fetch(0);
      fetch(1);

      for (int r = 0; r < 4; r++) begin
         int n;
         bit wl;
         n = $urandom_range(1, 40);
         wl = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
         img = {};
         for (int i = 0; i < n; i++) img.push_back($urandom);
         load_img(wl);
         for (int k = 0; k < 5; k++) fetch($urandom_range(0, 63));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
